// File: rtl/ysyx_22050710_csr_file.sv
// M-mode CSR file: read port, read-modify-write port, trap entry/mret, timer interrupt, counters.
// Latency: reads and o_irq/o_illegal are combinational; writes and trap updates commit at the next i_clk edge.
// Backpressure: none; every event is accepted in the cycle it is presented.
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_ren/i_raddr        read port -> o_csrrdata (0 when disabled or address unimplemented)
//   i_wen/i_waddr/i_wdata/i_wop  write port (00 write, 01 set, 10 clear, 11 no-op)
//   o_illegal            unimplemented read address, or unimplemented/read-only write address
//   i_ecall_sel, i_irq_ack, i_mret_sel, i_epc   trap entry / return controls
//   i_instret, i_mtip    retire pulse and machine timer interrupt level
//   o_irq, o_mtvec, o_mepc   to pipeline control and PC select
module ysyx_22050710_csr_file #(
  parameter int          ADDR_WIDTH   = 12,
  parameter int          DATA_WIDTH   = 64,
  parameter logic [63:0] MSTATUS_RST  = 64'ha00001800,
  parameter bit          HAS_COUNTERS = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ren,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_csrrdata,
  input  logic                  i_wen,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_wop,
  output logic                  o_illegal,
  input  logic                  i_ecall_sel,
  input  logic                  i_irq_ack,
  input  logic                  i_mret_sel,
  input  logic [DATA_WIDTH-1:0] i_epc,
  input  logic                  i_instret,
  input  logic                  i_mtip,
  output logic                  o_irq,
  output logic [DATA_WIDTH-1:0] o_mtvec,
  output logic [DATA_WIDTH-1:0] o_mepc
);

  localparam int DW = DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] A_MSTATUS  = ADDR_WIDTH'(12'h300);
  localparam logic [ADDR_WIDTH-1:0] A_MIE      = ADDR_WIDTH'(12'h304);
  localparam logic [ADDR_WIDTH-1:0] A_MTVEC    = ADDR_WIDTH'(12'h305);
  localparam logic [ADDR_WIDTH-1:0] A_MSCRATCH = ADDR_WIDTH'(12'h340);
  localparam logic [ADDR_WIDTH-1:0] A_MEPC     = ADDR_WIDTH'(12'h341);
  localparam logic [ADDR_WIDTH-1:0] A_MCAUSE   = ADDR_WIDTH'(12'h342);
  localparam logic [ADDR_WIDTH-1:0] A_MIP      = ADDR_WIDTH'(12'h344);
  localparam logic [ADDR_WIDTH-1:0] A_MCYCLE   = ADDR_WIDTH'(12'hB00);
  localparam logic [ADDR_WIDTH-1:0] A_MINSTRET = ADDR_WIDTH'(12'hB02);

  // Direct-mode vectors and word-aligned PCs: low two bits always stored as 0.
  localparam logic [DW-1:0] ALIGN_MASK = {{(DW-2){1'b1}}, 2'b00};
  localparam logic [DW-1:0] MTIE_MASK  = DW'(8'h80);
  localparam logic [DW-1:0] CAUSE_MTI  = {1'b1, (DW-1)'(7)};
  localparam logic [DW-1:0] CAUSE_ECALL = DW'(11);

  logic [DW-1:0] mstatus_q,  mstatus_d;
  logic [DW-1:0] mie_q,      mie_d;
  logic [DW-1:0] mtvec_q,    mtvec_d;
  logic [DW-1:0] mscratch_q, mscratch_d;
  logic [DW-1:0] mepc_q,     mepc_d;
  logic [DW-1:0] mcause_q,   mcause_d;
  logic [DW-1:0] mcycle_q,   mcycle_d;
  logic [DW-1:0] minstret_q, minstret_d;
  logic [DW-1:0] mip_w;

  // mip is derived from the live timer line, never stored.
  assign mip_w = DW'({i_mtip, 7'b0});

  // Returns {implemented, value} for an address from current state.
  // Counter addresses are always "implemented"; without counters the
  // registers simply stay at 0.
  function automatic logic [DW:0] csr_lookup(input logic [ADDR_WIDTH-1:0] a);
    logic [DW:0] r;
    r = '0;
    case (a)
      A_MSTATUS:  r = {1'b1, mstatus_q};
      A_MIE:      r = {1'b1, mie_q};
      A_MTVEC:    r = {1'b1, mtvec_q};
      A_MSCRATCH: r = {1'b1, mscratch_q};
      A_MEPC:     r = {1'b1, mepc_q};
      A_MCAUSE:   r = {1'b1, mcause_q};
      A_MIP:      r = {1'b1, mip_w};
      A_MCYCLE:   r = {1'b1, mcycle_q};
      A_MINSTRET: r = {1'b1, minstret_q};
      default:    r = '0;
    endcase
    return r;
  endfunction

  logic [DW:0]   rd_lk, wr_lk;
  logic [DW-1:0] wr_val;
  logic          wop_ok, wr_ro, wr_en, trap, evt;

  assign rd_lk  = csr_lookup(i_raddr);
  assign wr_lk  = csr_lookup(i_waddr);
  assign wop_ok = (i_wop != 2'b11);
  assign wr_ro  = (i_waddr == A_MIP);
  assign wr_en  = i_wen & wop_ok & wr_lk[DW] & ~wr_ro;
  assign trap   = i_irq_ack | i_ecall_sel;
  assign evt    = trap | i_mret_sel;

  assign o_csrrdata = i_ren ? rd_lk[DW-1:0] : '0;
  // A reserved op is a no-op, so it never flags the write side.
  assign o_illegal  = (i_ren & ~rd_lk[DW]) | (i_wen & wop_ok & (~wr_lk[DW] | wr_ro));
  assign o_irq      = mstatus_q[3] & mie_q[7] & i_mtip;
  assign o_mtvec    = mtvec_q;
  assign o_mepc     = mepc_q;

  always_comb begin
    wr_val = i_wdata;
    case (i_wop)
      2'b01:   wr_val = wr_lk[DW-1:0] | i_wdata;
      2'b10:   wr_val = wr_lk[DW-1:0] & ~i_wdata;
      default: wr_val = i_wdata;
    endcase
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;

    if (HAS_COUNTERS) begin
      mcycle_d = mcycle_q + DW'(1);
      if (i_instret) minstret_d = minstret_q + DW'(1);
    end

    // Trap/mret own mstatus, mepc and mcause in their cycle; a CSR write
    // to those is dropped, while writes elsewhere still land.
    if (wr_en) begin
      case (i_waddr)
        A_MSTATUS:  if (!evt) mstatus_d = wr_val;
        A_MIE:      mie_d = wr_val & MTIE_MASK;
        A_MTVEC:    mtvec_d = wr_val & ALIGN_MASK;
        A_MSCRATCH: mscratch_d = wr_val;
        A_MEPC:     if (!evt) mepc_d = wr_val & ALIGN_MASK;
        A_MCAUSE:   if (!evt) mcause_d = wr_val;
        A_MCYCLE:   if (HAS_COUNTERS) mcycle_d = wr_val;
        A_MINSTRET: if (HAS_COUNTERS) minstret_d = wr_val;
        default:    ;
      endcase
    end

    if (trap) begin
      mepc_d           = i_epc & ALIGN_MASK;
      mcause_d         = i_irq_ack ? CAUSE_MTI : CAUSE_ECALL;
      mstatus_d        = mstatus_q;
      mstatus_d[7]     = mstatus_q[3];
      mstatus_d[3]     = 1'b0;
      mstatus_d[12:11] = 2'b11;
    end else if (i_mret_sel) begin
      mstatus_d        = mstatus_q;
      mstatus_d[3]     = mstatus_q[7];
      mstatus_d[7]     = 1'b1;
      mstatus_d[12:11] = 2'b11;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mstatus_q  <= MSTATUS_RST[DW-1:0];
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

endmodule
